// File: rtl/mat_mult_2x2_arbiter_if.sv
// Bundles the requester, multiplier and response signals of the 2x2 matrix-multiply
// arbiter. The master view belongs to the arbiter. The slave view belongs to the
// client engines and the multiplier that surround it.
interface mat_mult_2x2_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_data;
  logic                 mm_start;
  logic [15:0]          mm_a, mm_b, mm_c, mm_d, mm_e, mm_f, mm_g, mm_h;
  logic [31:0]          mm_w, mm_x, mm_y, mm_z;
  logic                 mm_done;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_w, rsp_x, rsp_y, rsp_z;
  logic [IDW:0]         inflight;
  logic                 err;

  modport master (
    input  en, req_valid, req_data, mm_w, mm_x, mm_y, mm_z, mm_done,
    output req_ready, mm_start, mm_a, mm_b, mm_c, mm_d, mm_e, mm_f, mm_g, mm_h,
    output rsp_valid, rsp_id, rsp_w, rsp_x, rsp_y, rsp_z, inflight, err
  );

  modport slave (
    output en, req_valid, req_data, mm_w, mm_x, mm_y, mm_z, mm_done,
    input  req_ready, mm_start, mm_a, mm_b, mm_c, mm_d, mm_e, mm_f, mm_g, mm_h,
    input  rsp_valid, rsp_id, rsp_w, rsp_x, rsp_y, rsp_z, inflight, err
  );
endinterface

// File: rtl/mat_mult_2x2_arbiter.sv
// Round-robin scheduler for one shared pipelined 2x2 multiplier. It accepts at most
// one job per cycle and forwards the job's operands to the multiplier. Each job's
// requester ID travels down a tag pipe that lines up with mm_done, so every result
// comes back tagged with the requester that issued it.
module mat_mult_2x2_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  mat_mult_2x2_arbiter_if.master bus
);

  logic [IDW-1:0]  r_rr_ptr;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_win;
  logic            w_any;
  logic [127:0]    w_job;
  logic            r_mm_start;
  logic [127:0]    r_mm_ops;
  // Each tag is {valid, id}. Stage 0 lines up with mm_start and stage LAT with mm_done.
  logic [IDW:0]    r_tag [LAT+1];
  logic            w_tag_valid;
  logic [IDW-1:0]  w_tag_id;
  logic            w_capture;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [31:0]     r_rsp_w, r_rsp_x, r_rsp_y, r_rsp_z;
  logic [IDW:0]    r_inflight;
  logic            r_err;

  // Winner is the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    if (bus.en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_any && bus.req_valid[(int'(r_rr_ptr) + i) % NREQ]) begin
          w_any = 1'b1;
          w_win = IDW'((int'(r_rr_ptr) + i) % NREQ);
        end
      end
      if (w_any) w_grant[w_win] = 1'b1;
    end
  end

  assign w_job       = bus.req_data[w_win*128 +: 128];
  assign w_tag_valid = r_tag[LAT][IDW];
  assign w_tag_id    = r_tag[LAT][IDW-1:0];
  assign w_capture   = bus.mm_done && w_tag_valid;

  // Launch the accepted job into the multiplier and advance the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mm_start <= 1'b0;
      r_mm_ops   <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_mm_start <= w_any;
      if (w_any) begin
        r_mm_ops <= w_job;
        r_rr_ptr <= IDW'((int'(w_win) + 1) % NREQ);
      end
    end
  end

  // The tag pipe shifts every cycle, so its output valid coincides with mm_done of the same job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= w_any ? {1'b1, w_win} : '0;
      for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Register a tagged response. The rsp_* data fields hold their value between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_w     <= '0;
      r_rsp_x     <= '0;
      r_rsp_y     <= '0;
      r_rsp_z     <= '0;
    end else begin
      r_rsp_valid <= w_capture;
      if (w_capture) begin
        r_rsp_id <= w_tag_id;
        r_rsp_w  <= bus.mm_w;
        r_rsp_x  <= bus.mm_x;
        r_rsp_y  <= bus.mm_y;
        r_rsp_z  <= bus.mm_z;
      end
    end
  end

  // A job counts as in flight from its grant until the cycle its response is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_any, r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + (IDW+1)'(1);
        2'b01:   r_inflight <= r_inflight - (IDW+1)'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Any disagreement between mm_done and the tag pipe sets the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= r_err | (bus.mm_done ^ w_tag_valid);
  end

  assign bus.req_ready = w_grant;
  assign bus.mm_start  = r_mm_start;
  assign bus.mm_a      = r_mm_ops[127:112];
  assign bus.mm_b      = r_mm_ops[111:96];
  assign bus.mm_c      = r_mm_ops[95:80];
  assign bus.mm_d      = r_mm_ops[79:64];
  assign bus.mm_e      = r_mm_ops[63:48];
  assign bus.mm_f      = r_mm_ops[47:32];
  assign bus.mm_g      = r_mm_ops[31:16];
  assign bus.mm_h      = r_mm_ops[15:0];
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_w     = r_rsp_w;
  assign bus.rsp_x     = r_rsp_x;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_z     = r_rsp_z;
  assign bus.inflight  = r_inflight;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mat_mult_2x2_arbiter.sv
// Directed bench for mat_mult_2x2_arbiter. It includes a behavioural 3-cycle signed
// 2x2 multiplier that shares the DUT reset.
module tb_mat_mult_2x2_arbiter;
  logic clk;
  logic reset;
  logic force_done;
  int   n_run;
  int   n_fail;
  logic [31:0] exp_w [4];

  mat_mult_2x2_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  mat_mult_2x2_arbiter #(.NREQ(4), .IDW(2), .LAT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mul(input logic [15:0] p, input logic [15:0] q);
    logic signed [31:0] sp;
    logic signed [31:0] sq;
    sp = {{16{p[15]}}, p};
    sq = {{16{q[15]}}, q};
    return sp * sq;
  endfunction

  function automatic logic [127:0] job(input logic [15:0] a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  // Multiplier model: results are produced three cycles after mm_start.
  logic        p_v [3];
  logic [31:0] p_w [3], p_x [3], p_y [3], p_z [3];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) p_v[k] <= 1'b0;
    end else begin
      p_v[0] <= bus.mm_start;
      p_w[0] <= mul(bus.mm_a, bus.mm_e) + mul(bus.mm_b, bus.mm_g);
      p_x[0] <= mul(bus.mm_a, bus.mm_f) + mul(bus.mm_b, bus.mm_h);
      p_y[0] <= mul(bus.mm_c, bus.mm_e) + mul(bus.mm_d, bus.mm_g);
      p_z[0] <= mul(bus.mm_c, bus.mm_f) + mul(bus.mm_d, bus.mm_h);
      for (int k = 1; k < 3; k++) begin
        p_v[k] <= p_v[k-1];
        p_w[k] <= p_w[k-1];
        p_x[k] <= p_x[k-1];
        p_y[k] <= p_y[k-1];
        p_z[k] <= p_z[k-1];
      end
    end
  end
  assign bus.mm_done = p_v[2] | force_done;
  assign bus.mm_w    = p_w[2];
  assign bus.mm_x    = p_x[2];
  assign bus.mm_y    = p_y[2];
  assign bus.mm_z    = p_z[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_run = 0;
    n_fail = 0;
    exp_w = '{32'd1, 32'd2, 32'd3, 32'd4};
    force_done = 1'b0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    repeat (2) tick();

    chk("rst_mm_start", 32'(bus.mm_start), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_mm_a", 32'(bus.mm_a), 32'd0);
    reset = 1'b1;
    tick();

    // Single job from requester 1
    bus.req_data[1*128 +: 128] = job(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    bus.en = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    chk("t1_mm_start", 32'(bus.mm_start), 32'd1);
    chk("t1_mm_a", 32'(bus.mm_a), 32'd1);
    chk("t1_mm_h", 32'(bus.mm_h), 32'd8);
    chk("t1_inflight1", 32'(bus.inflight), 32'd1);
    tick();
    chk("t1_mm_start_low", 32'(bus.mm_start), 32'd0);
    repeat (2) tick();
    chk("t1_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(bus.rsp_id), 32'd1);
    chk("t1_w", bus.rsp_w, 32'd19);
    chk("t1_x", bus.rsp_x, 32'd22);
    chk("t1_y", bus.rsp_y, 32'd43);
    chk("t1_z", bus.rsp_z, 32'd50);
    chk("t1_inflight_rsp", 32'(bus.inflight), 32'd1);
    tick();
    chk("t1_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    chk("t1_inflight0", 32'(bus.inflight), 32'd0);
    chk("t1_err", 32'(bus.err), 32'd0);

    // Signed operands, requester 3 (pointer now 2)
    bus.req_data[3*128 +: 128] = job(16'hFFFE, 16'd3, 16'h8000, 16'd0,
                                     16'd4, 16'hFFFF, 16'd5, 16'd2);
    bus.req_valid = 4'b1000;
    #1;
    chk("t2_ready", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = '0;
    chk("t2_mm_start", 32'(bus.mm_start), 32'd1);
    repeat (4) tick();
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_rsp_id", 32'(bus.rsp_id), 32'd3);
    chk("t2_w", bus.rsp_w, 32'd7);
    chk("t2_x", bus.rsp_x, 32'd8);
    chk("t2_y", bus.rsp_y, 32'hFFFE0000);
    chk("t2_z", bus.rsp_z, 32'h00008000);
    tick();

    // Round-robin from reset, all requesters valid for 8 cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      bus.req_data[i*128 +: 128] = job(16'(i + 1), 16'd0, 16'd0, 16'd1,
                                       16'd1, 16'd2, 16'd3, 16'd4);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      if (k == 8) bus.req_valid = '0;
      #1;
      if (k < 8) chk($sformatf("rr_grant_%0d", k), 32'(bus.req_ready), 32'd1 << (k % 4));
      else       chk($sformatf("rr_idle_%0d", k), 32'(bus.req_ready), 32'd0);
      if (k >= 5) begin
        chk($sformatf("rr_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("rr_rsp_id_%0d", k), 32'(bus.rsp_id), 32'((k - 5) % 4));
        chk($sformatf("rr_rsp_w_%0d", k), bus.rsp_w, exp_w[(k - 5) % 4]);
      end else begin
        chk($sformatf("rr_no_rsp_%0d", k), 32'(bus.rsp_valid), 32'd0);
      end
      chk($sformatf("rr_inflight_%0d", k), 32'(bus.inflight),
          (k <= 5) ? 32'(k) : ((k <= 8) ? 32'd5 : 32'(13 - k)));
      tick();
    end
    chk("rr_done_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rr_done_inflight", 32'(bus.inflight), 32'd0);

    // Enable gating with requesters 0 and 2
    bus.en = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    chk("en0_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("en0_ready_b", 32'(bus.req_ready), 32'd0);
    chk("en0_no_start", 32'(bus.mm_start), 32'd0);
    tick();
    chk("en0_no_start_b", 32'(bus.mm_start), 32'd0);
    bus.en = 1'b1;
    #1;
    chk("en1_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0100;
    #1;
    chk("en1_start0", 32'(bus.mm_start), 32'd1);
    chk("en1_mm_a0", 32'(bus.mm_a), 32'd1);
    chk("en1_grant2", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = '0;
    chk("en1_start2", 32'(bus.mm_start), 32'd1);
    chk("en1_mm_a2", 32'(bus.mm_a), 32'd3);
    repeat (6) tick();
    chk("en_drain_inflight", 32'(bus.inflight), 32'd0);

    // Reset while two jobs are in flight
    bus.req_valid = 4'b0001;
    #1;
    chk("rmf_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0010;
    #1;
    chk("rmf_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    chk("rmf_inflight2", 32'(bus.inflight), 32'd2);
    reset = 1'b0;
    #1;
    chk("rmf_mm_start", 32'(bus.mm_start), 32'd0);
    chk("rmf_inflight", 32'(bus.inflight), 32'd0);
    chk("rmf_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rmf_mm_a", 32'(bus.mm_a), 32'd0);
    chk("rmf_err", 32'(bus.err), 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rmf_no_rsp_%0d", k), 32'(bus.rsp_valid), 32'd0);
    end
    chk("rmf_inflight_end", 32'(bus.inflight), 32'd0);
    chk("rmf_err_end", 32'(bus.err), 32'd0);

    // Spurious mm_done with nothing in flight
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("mm_err_set", 32'(bus.err), 32'd1);
    chk("mm_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("mm_err_sticky", 32'(bus.err), 32'd1);
    chk("mm_no_rsp_b", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("mm_err_sticky_b", 32'(bus.err), 32'd1);
    chk("mm_inflight", 32'(bus.inflight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
